// File: rtl/adiabatic_pkg.sv
// Shared types and the ramp level map for the adiabatic power-clock sequencer.
package adiabatic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    STOP
  } seq_state_e;

  function automatic int phase_level(int p, int r, int h);
    if (p < r) return p + 1;
    if (p < r + h) return r;
    if (p < 2 * r + h) return 2 * r + h - 1 - p;
    return 0;
  endfunction

endpackage

// File: rtl/adiabatic_phase_wave.sv
// One power-clock phase: maps the global counter to this phase's level code.
module adiabatic_phase_wave
  import adiabatic_pkg::*;
#(
  parameter int NUM_PHASES  = 4,
  parameter int RAMP_STEPS  = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int IDX         = 0,
  localparam int P     = 2 * RAMP_STEPS + 2 * HOLD_CYCLES,
  localparam int OFF   = P / NUM_PHASES,
  localparam int LW    = $clog2(RAMP_STEPS + 1),
  localparam int CW    = $clog2(P),
  localparam int SW    = CW + 1,
  localparam int SHIFT = IDX * OFF
) (
  input  logic [CW-1:0] cnt,
  input  logic          active,
  output logic [LW-1:0] level
);

  logic [SW-1:0] sum;
  logic [CW-1:0] pos;

  // (cnt - SHIFT) mod P without a divider
  always_comb begin
    sum = {1'b0, cnt} + SW'(P - SHIFT);
    pos = (sum >= SW'(P)) ? CW'(sum - SW'(P)) : CW'(sum);
    level = active
      ? LW'(phase_level(32'(pos), RAMP_STEPS, HOLD_CYCLES))
      : '0;
  end

endmodule

// File: rtl/adiabatic_phase_sequencer.sv
// Staggered stepwise-ramped power-clock sequencer with draining stop.
module adiabatic_phase_sequencer
  import adiabatic_pkg::*;
#(
  parameter int NUM_PHASES  = 4,
  parameter int RAMP_STEPS  = 4,
  parameter int HOLD_CYCLES = 2,
  localparam int P   = 2 * RAMP_STEPS + 2 * HOLD_CYCLES,
  localparam int OFF = P / NUM_PHASES,
  localparam int LW  = $clog2(RAMP_STEPS + 1),
  localparam int CW  = $clog2(P)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run_req,
  input  logic                     stall,
  output logic [NUM_PHASES*LW-1:0] phase_level,
  output logic [NUM_PHASES-1:0]    phase_active,
  output logic                     busy,
  output logic                     period_done
);

  if (P % NUM_PHASES != 0 || RAMP_STEPS < 1 || HOLD_CYCLES < 1) begin : g_bad
    $error("adiabatic_phase_sequencer: illegal parameters");
  end

  localparam logic [CW-1:0] LAST = CW'(P - 1);

  seq_state_e            state, state_n;
  logic [CW-1:0]         cnt, cnt_n, cnt_inc;
  logic [NUM_PHASES-1:0] active, active_n;
  logic                  pdone_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      active      <= '0;
      period_done <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      active      <= active_n;
      period_done <= pdone_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    active_n = active;
    pdone_n  = 1'b0;
    cnt_inc  = (cnt == LAST) ? '0 : cnt + CW'(1);
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (run_req) begin
          state_n  = START;
          active_n = NUM_PHASES'(1);
        end
      end
      START: begin
        if (!stall) begin
          cnt_n = cnt_inc;
          if (!run_req) begin
            state_n = STOP;
          end else begin
            for (int i = 0; i < NUM_PHASES; i++)
              if (cnt_inc == CW'(i * OFF)) active_n[i] = 1'b1;
            if (active_n[NUM_PHASES-1]) state_n = RUN;
          end
        end
      end
      RUN: begin
        if (!stall) begin
          cnt_n   = cnt_inc;
          pdone_n = (cnt == LAST);
          if (!run_req) state_n = STOP;
        end
      end
      STOP: begin
        if (!stall) begin
          cnt_n = cnt_inc;
          // retire a phase as its local position wraps back to 0
          for (int i = 0; i < NUM_PHASES; i++)
            if (cnt == CW'((i * OFF + P - 1) % P)) active_n[i] = 1'b0;
          if (active_n == '0) begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
      end
    endcase
  end

  for (genvar g = 0; g < NUM_PHASES; g++) begin : g_wave
    adiabatic_phase_wave #(
      .NUM_PHASES (NUM_PHASES),
      .RAMP_STEPS (RAMP_STEPS),
      .HOLD_CYCLES(HOLD_CYCLES),
      .IDX        (g)
    ) u_wave (
      .cnt   (cnt),
      .active(active[g]),
      .level (phase_level[g*LW +: LW])
    );
  end

  assign phase_active = active;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_adiabatic_phase_sequencer.sv
// Scoreboard bench for adiabatic_phase_sequencer against a per-phase age model.
module tb_adiabatic_phase_sequencer;

  localparam int NP  = 4;
  localparam int R   = 4;
  localparam int H   = 2;
  localparam int P   = 2 * R + 2 * H;
  localparam int OFF = P / NP;
  localparam int LW  = 3;

  typedef struct packed {
    logic [NP*LW-1:0] lv;
    logic [NP-1:0]    act;
    logic             busy;
    logic             pd;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             run_req = 1'b0;
  logic             stall = 1'b0;
  logic [NP*LW-1:0] phase_level;
  logic [NP-1:0]    phase_active;
  logic             busy;
  logic             period_done;

  adiabatic_phase_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .run_req     (run_req),
    .stall       (stall),
    .phase_level (phase_level),
    .phase_active(phase_active),
    .busy        (busy),
    .period_done (period_done)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int wave[P];
  int pos[NP];
  bit on[NP];
  bit m_busy, m_drain, m_pd;
  int elapsed;

  function automatic bit none_on();
    for (int i = 0; i < NP; i++) if (on[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input bit r, input bit rq, input bit st);
    bit was_drain, was_full;
    m_pd = 1'b0;
    if (r) begin
      m_busy = 0; m_drain = 0; elapsed = 0;
      for (int i = 0; i < NP; i++) begin on[i] = 0; pos[i] = 0; end
    end else if (!m_busy) begin
      if (rq) begin
        m_busy = 1; m_drain = 0; elapsed = 0;
        on[0] = 1; pos[0] = 0;
      end
    end else if (!st) begin
      was_drain = m_drain;
      was_full  = on[NP-1];
      m_pd = !was_drain && was_full && pos[0] == P - 1;
      for (int i = 0; i < NP; i++)
        if (on[i]) begin
          if (was_drain && pos[i] == P - 1) on[i] = 0;
          pos[i] = (pos[i] + 1) % P;
        end
      elapsed++;
      if (!was_drain) begin
        if (!rq) m_drain = 1;
        else if (!was_full)
          for (int i = 1; i < NP; i++)
            if (!on[i] && elapsed == i * OFF) begin on[i] = 1; pos[i] = 0; end
      end
      if (was_drain && none_on()) m_busy = 0;
    end
  endtask

  task automatic cycle(input bit r, input bit rq, input bit st);
    exp_t e;
    @(negedge clk);
    rst = r; run_req = rq; stall = st;
    model_step(r, rq, st);
    e.lv = '0;
    for (int i = 0; i < NP; i++) begin
      e.act[i] = on[i];
      if (on[i]) e.lv[i*LW +: LW] = LW'(wave[pos[i]]);
    end
    e.busy = m_busy;
    e.pd   = m_pd;
    sb.push_back(e);
  endtask

  // Monitor: pop one expectation per clock once the DUT has updated
  initial begin
    exp_t e, got;
    logic [NP*LW-1:0] prev_lv;
    logic [NP-1:0]    prev_act;
    bit prev_ok = 0;
    int a, b;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        got = {phase_level, phase_active, busy, period_done};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t got lv=%h act=%b busy=%b pd=%b want lv=%h act=%b busy=%b pd=%b",
                   $time, got.lv, got.act, got.busy, got.pd, e.lv, e.act, e.busy, e.pd);
        end
        for (int i = 0; i < NP; i++)
          if (prev_ok && prev_act[i] && phase_active[i]) begin
            a = int'(prev_lv[i*LW +: LW]);
            b = int'(phase_level[i*LW +: LW]);
            checks++;
            if (a - b > 1 || b - a > 1) begin
              errors++;
              $display("FAIL level_step phase%0d t=%0t got %0d->%0d want step<=1", i, $time, a, b);
            end
          end
        prev_lv  = phase_level;
        prev_act = phase_active;
        prev_ok  = 1;
      end
    end
  end

  initial begin
    int idx = 0;
    bit rq;
    for (int k = 1; k <= R; k++) wave[idx++] = k;
    for (int k = 0; k < H; k++) wave[idx++] = R;
    for (int k = R - 1; k >= 0; k--) wave[idx++] = k;
    for (int k = 0; k < H; k++) wave[idx++] = 0;
    m_busy = 0; m_drain = 0; elapsed = 0;
    for (int i = 0; i < NP; i++) begin on[i] = 0; pos[i] = 0; end

    repeat (2) cycle(1, 0, 0);
    repeat (3) cycle(0, 0, 1);
    repeat (30) cycle(0, 1, 0);
    for (int k = 0; k < 20 && !(on[0] && pos[0] == R); k++) cycle(0, 1, 0);
    repeat (5) cycle(0, 1, 1);
    repeat (6) cycle(0, 1, 0);
    for (int k = 0; k < 40 && m_busy; k++) cycle(0, 0, 0);
    cycle(0, 0, 0);

    for (int k = 0; k < 20 && !on[1]; k++) cycle(0, 1, 0);
    for (int k = 0; k < 40 && m_busy; k++) cycle(0, 0, 0);
    cycle(0, 0, 0);

    for (int k = 0; k < 30 && !on[NP-1]; k++) cycle(0, 1, 0);
    repeat (4) cycle(0, 0, 0);
    repeat (40) cycle(0, 1, 0);

    for (int k = 0; k < 30 && !(on[2] && wave[pos[2]] == R); k++) cycle(0, 1, 0);
    cycle(1, 1, 0);
    repeat (3) cycle(0, 0, 0);

    rq = 0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 19) == 0) rq = ~rq;
      cycle($urandom_range(0, 299) == 0, rq, $urandom_range(0, 6) == 0);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_queue got %0d pending want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
